score_min_select: RTL and testbench
===================================

// Module: score_min_select
// PURPOSE
//  Downstream of the per-task score calculator. Collects one fp32 score per active task per
//  scheduling round and selects the task with the lowest score for dispatch.
//  Scores arrive serially on a valid/ready stream tagged with task id. The winner is presented
//  on a held valid/ready output to the dispatcher.
// PARAMETERS
//  NUM_TASKS       8                    number of schedulable tasks (>=2)
//  SCORE_BITWIDTH  32                   score width; IEEE-754 single precision
//  ID_WIDTH        $clog2(NUM_TASKS)    task id width
//  TIMEOUT_CYCLES  1024                 collect timeout; used only with SCORE_SEL_TIMEOUT_EN
// PORTS
//  clk          in   1               clock
//  reset_n      in   1               asynchronous active-low reset
//  round_start  in   1               start a round; sampled only in IDLE
//  task_mask    in   NUM_TASKS       active tasks for the round; latched with round_start
//  score_vld    in   1               score beat valid
//  score_rdy    out  1               high only in COLLECT
//  score_id     in   ID_WIDTH        task id of the beat
//  score_dat    in   SCORE_BITWIDTH  fp32 score
//  sel_vld      out  1               result valid; held until sel_rdy
//  sel_rdy      in   1               dispatcher accepts the result
//  sel_id       out  ID_WIDTH        winning task id
//  sel_score    out  SCORE_BITWIDTH  winning score
//  sel_empty    out  1               round had no valid winner
//  drop_cnt     out  8               saturating count of dropped beats; cleared at round_start
//  busy         out  1               state != IDLE
// BEHAVIOUR
//  Reset
//  - Every output and register returns to 0 immediately. State = IDLE.
//  - Reset mid-round discards the round completely. No output is produced for it.
//  FSM
//  - IDLE -> COLLECT: on round_start with task_mask != 0.
//    Latch pending = task_mask. Clear best_valid and drop_cnt.
//  - IDLE -> OUTPUT: on round_start with task_mask == 0.
//    sel_empty = 1, sel_id = 0, sel_score = 0.
//  - COLLECT -> OUTPUT: the cycle after the beat that clears the last pending bit.
//    sel_vld is high on the cycle after that accept (latency 1).
//  - OUTPUT -> IDLE: on sel_vld & sel_rdy.
//    A round_start in that same cycle is ignored. round_start is ignored in any state other than IDLE.
//  Beat accept (score_vld & score_rdy)
//  - score_id >= NUM_TASKS, or its pending bit is 0 (inactive or duplicate):
//    drop the beat and increment drop_cnt (saturates at 255). Best is unchanged.
//  - Otherwise: clear the pending bit. Replace best if the beat wins the comparison below.
//  Compare
//  - Mapped key k: if sign = 0, k = {1, bits[30:0]}; if sign = 1, k = ~bits.
//    The smaller unsigned k wins.
//  - -0 is mapped to +0 before comparison.
//  - NaN (exp = 0xFF, mantissa != 0) ranks above every non-NaN value.
//  - Equal keys: the lower task id wins. The result is therefore independent of arrival order.
//  Result
//  - sel_id / sel_score come from registered best.
//  - If every accepted score was NaN, the NaN with the lowest id wins and sel_empty = 0.
//  - sel_* outputs are stable while sel_vld = 1 and sel_rdy = 0.
// CONFIGURATION
//  SCORE_SEL_TIMEOUT_EN defined
//  - A 16-bit counter runs in COLLECT.
//  - After TIMEOUT_CYCLES cycles without completion, go to OUTPUT with best-so-far and sel_timeout = 1.
//  - If no beat was accepted: sel_empty = 1, sel_id = 0, sel_score = 0.
//  - Extra port: sel_timeout  out  1  round ended by timeout; valid with sel_vld, 0 at reset.
//  - A beat accepted in the timeout cycle is included in the result.
//  SCORE_SEL_TIMEOUT_EN undefined
//  - No counter and no sel_timeout port. COLLECT waits indefinitely.
// TESTING
//  1. Mask 0x0F; scores id0 = 3.0, id1 = 1.5, id2 = -2.0, id3 = 0.5.
//     -> sel_vld 1 cycle after the 4th accept, sel_id = 2, sel_score = 0xC0000000.
//  2. Mask 0x05; id2 = 1.0 (0x3F800000), then id0 = 1.0 (0x3F800000).
//     -> sel_id = 0 (tie-break on lower id).
//  3. Mask 0x03; beats id1 = 4.0, id1 = 0.1 (duplicate), id5 = 0.0 (inactive), id0 = 8.0.
//     -> sel_id = 1, sel_score = 0x40800000, drop_cnt = 2.
//  4. round_start with mask 0x00. -> next cycle sel_vld = 1, sel_empty = 1.
//     Hold sel_rdy = 0 for 5 cycles -> outputs stable. busy = 1 until the handshake.
//  5. Deassert reset_n mid-COLLECT (1 of 3 scores received) -> all outputs 0 at once.
//     New round with mask 0x01, id0 = +0 (0x00000000)
//     -> sel_id = 0, sel_score = 0x00000000, drop_cnt = 0.
//  6. With SCORE_SEL_TIMEOUT_EN, TIMEOUT_CYCLES = 16, mask 0x07, only id1 = 2.0 sent.
//     -> sel_vld at cycle 16 of COLLECT, sel_id = 1, sel_timeout = 1.

Source files
------------

// File: rtl/score_min_select_if.sv
// score_min_select_if: round control, score stream and result handshake bundle for score_min_select
//  master (scheduler/dispatcher side) drives round_start, task_mask, score_vld/id/dat, sel_rdy
//  slave  (score_min_select) drives score_rdy, sel_vld/id/score/empty, drop_cnt, busy
//  Option macro SCORE_SEL_TIMEOUT_EN adds sel_timeout (slave -> master).
interface score_min_select_if #(
   parameter int NUM_TASKS      = 8,
   parameter int SCORE_BITWIDTH = 32,
   parameter int ID_WIDTH       = $clog2(NUM_TASKS)
);
   logic                      round_start;
   logic [NUM_TASKS-1:0]      task_mask;
   logic                      score_vld;
   logic                      score_rdy;
   logic [ID_WIDTH-1:0]       score_id;
   logic [SCORE_BITWIDTH-1:0] score_dat;
   logic                      sel_vld;
   logic                      sel_rdy;
   logic [ID_WIDTH-1:0]       sel_id;
   logic [SCORE_BITWIDTH-1:0] sel_score;
   logic                      sel_empty;
   logic [7:0]                drop_cnt;
   logic                      busy;
`ifdef SCORE_SEL_TIMEOUT_EN
   logic                      sel_timeout;
`endif
   modport master (
      output round_start, task_mask, score_vld, score_id, score_dat, sel_rdy,
      input  score_rdy, sel_vld, sel_id, sel_score, sel_empty, drop_cnt, busy
`ifdef SCORE_SEL_TIMEOUT_EN
     ,input  sel_timeout
`endif
   );
   modport slave (
      input  round_start, task_mask, score_vld, score_id, score_dat, sel_rdy,
      output score_rdy, sel_vld, sel_id, sel_score, sel_empty, drop_cnt, busy
`ifdef SCORE_SEL_TIMEOUT_EN
     ,output sel_timeout
`endif
   );
endinterface

// File: rtl/score_min_select.sv
// score_min_select: collects one fp32 score per active task per round and presents the lowest
//  Ports: clk_i, reset_n_i (async active-low), bus (score_min_select_if.slave):
//   round_start/task_mask start a round from IDLE; score_vld/rdy/id/dat carry the scores;
//   sel_vld/rdy/id/score/empty hold the winner; drop_cnt counts dropped beats; busy = not IDLE.
//  Option macro SCORE_SEL_TIMEOUT_EN: COLLECT ends after TIMEOUT_CYCLES cycles, flagged on sel_timeout.
module score_min_select #(
   parameter int NUM_TASKS      = 8,
   parameter int SCORE_BITWIDTH = 32,
   parameter int ID_WIDTH       = $clog2(NUM_TASKS)
`ifdef SCORE_SEL_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input logic               clk_i,
   input logic               reset_n_i,
   score_min_select_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;
   state_t                    state_q, state_d;
   logic [NUM_TASKS-1:0]      pend_q, pend_d, clr;
   logic                      best_vld_q, best_vld_d;
   logic [ID_WIDTH-1:0]       best_id_q, best_id_d;
   logic [SCORE_BITWIDTH-1:0] best_dat_q, best_dat_d;
   logic [7:0]                drop_q, drop_d;
   logic [SCORE_BITWIDTH:0]   key_b, key_q;
   logic                      accept, hit, wins, done;
`ifdef SCORE_SEL_TIMEOUT_EN
   logic [15:0]               cnt_q, cnt_d;
   logic                      to_q, to_d;
`endif
   // Order-preserving unsigned key; the extra MSB puts every NaN above all numbers, all NaNs equal
   function automatic logic [SCORE_BITWIDTH:0] key_f(input logic [SCORE_BITWIDTH-1:0] b);
      logic [SCORE_BITWIDTH-1:0] z;
      z = (b[SCORE_BITWIDTH-2:0] == '0) ? '0 : b;
      if (&b[30:23] && |b[22:0]) return '1;
      return {1'b0, z[SCORE_BITWIDTH-1] ? ~z : {1'b1, z[SCORE_BITWIDTH-2:0]}};
   endfunction
   assign key_b  = key_f(bus.score_dat);
   assign key_q  = key_f(best_dat_q);
   // Out-of-range ids shift the one-hot off the top and therefore never hit a pending bit
   assign clr    = NUM_TASKS'(1) << bus.score_id;
   assign accept = bus.score_vld && state_q == COLLECT;
   assign hit    = accept && |(pend_q & clr);
   assign done   = hit && (pend_q & ~clr) == '0;
   assign wins   = !best_vld_q || key_b < key_q || (key_b == key_q && bus.score_id < best_id_q);
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      best_vld_d = best_vld_q;
      best_id_d  = best_id_q;
      best_dat_d = best_dat_q;
      drop_d     = drop_q;
`ifdef SCORE_SEL_TIMEOUT_EN
      cnt_d      = cnt_q;
      to_d       = to_q;
`endif
      case (state_q)
         IDLE: if (bus.round_start) begin
            state_d    = |bus.task_mask ? COLLECT : OUTPUT;
            pend_d     = bus.task_mask;
            best_vld_d = 1'b0;
            best_id_d  = '0;
            best_dat_d = '0;
            drop_d     = '0;
`ifdef SCORE_SEL_TIMEOUT_EN
            cnt_d      = '0;
            to_d       = 1'b0;
`endif
         end
         COLLECT: begin
            if (hit) begin
               pend_d     = pend_q & ~clr;
               best_vld_d = 1'b1;
               best_id_d  = wins ? bus.score_id : best_id_q;
               best_dat_d = wins ? bus.score_dat : best_dat_q;
            end
            if (accept && !hit) drop_d = drop_q + 8'(drop_q != 8'hFF);
            if (done) state_d = OUTPUT;
`ifdef SCORE_SEL_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
            if (!done && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               state_d = OUTPUT;
               to_d    = 1'b1;
            end
`endif
         end
         OUTPUT: if (bus.sel_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         best_vld_q <= 1'b0;
         best_id_q  <= '0;
         best_dat_q <= '0;
         drop_q     <= '0;
`ifdef SCORE_SEL_TIMEOUT_EN
         cnt_q      <= '0;
         to_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         best_vld_q <= best_vld_d;
         best_id_q  <= best_id_d;
         best_dat_q <= best_dat_d;
         drop_q     <= drop_d;
`ifdef SCORE_SEL_TIMEOUT_EN
         cnt_q      <= cnt_d;
         to_q       <= to_d;
`endif
      end
   end
   assign bus.score_rdy = state_q == COLLECT;
   assign bus.sel_vld   = state_q == OUTPUT;
   assign bus.sel_id    = best_id_q;
   assign bus.sel_score = best_dat_q;
   assign bus.sel_empty = state_q == OUTPUT && !best_vld_q;
   assign bus.drop_cnt  = drop_q;
   assign bus.busy      = state_q != IDLE;
`ifdef SCORE_SEL_TIMEOUT_EN
   assign bus.sel_timeout = to_q;
`endif
endmodule

// File: tb/tb_score_min_select.sv
// tb_score_min_select: table vectors, corner sequences and random rounds against a real-valued model
module tb_score_min_select;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;

   score_min_select_if bus ();
`ifdef SCORE_SEL_TIMEOUT_EN
   score_min_select #(.TIMEOUT_CYCLES(16)) dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));
`else
   score_min_select dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));
`endif

   typedef struct packed {
      logic [7:0]        mask;
      int                n;
      logic [3:0][2:0]   id;
      logic [3:0][31:0]  dat;
      logic [2:0]        xid;
      logic [31:0]       xdat;
      logic [7:0]        xdrop;
   } vec_t;
   vec_t        vecs[$];
   logic [2:0]  q_id[$];
   logic [31:0] q_dat[$];
   logic [31:0] specials[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_nan(input logic [31:0] b);
      return b[30:23] == 8'hFF && b[22:0] != 23'd0;
   endfunction

   // Numeric value of an fp32 pattern; infinities become a magnitude beyond any finite fp32
   function automatic real val(input logic [31:0] b);
      real m;
      int  e;
      e = int'(b[30:23]);
      if (e == 255) m = 1.0e300;
      else if (e == 0) m = real'(b[22:0]) * (2.0 ** -149);
      else m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return b[31] ? -m : m;
   endfunction

   function automatic bit better(input logic [2:0] ai, input logic [31:0] ad,
                                 input logic [2:0] bi, input logic [31:0] bd);
      if (is_nan(ad) != is_nan(bd)) return is_nan(bd);
      if (!is_nan(ad) && val(ad) != val(bd)) return val(ad) < val(bd);
      return ai < bi;
   endfunction

   function automatic logic [31:0] rnd_dat();
      case ($urandom_range(0, 2))
         0: return $urandom;
         1: return specials[$urandom_range(0, 9)];
         default: return {$urandom_range(0, 1) == 1, 8'($urandom_range(124, 130)), 23'($urandom_range(0, 3) << 20)};
      endcase
   endfunction

   task automatic add_vec(input logic [7:0] mask, input int n,
                          input logic [2:0] i0, input logic [31:0] d0, input logic [2:0] i1, input logic [31:0] d1,
                          input logic [2:0] i2, input logic [31:0] d2, input logic [2:0] i3, input logic [31:0] d3,
                          input logic [2:0] xid, input logic [31:0] xdat, input logic [7:0] xdrop);
      vec_t v;
      v.mask = mask; v.n = n;
      v.id[0] = i0; v.id[1] = i1; v.id[2] = i2; v.id[3] = i3;
      v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
      v.xid = xid; v.xdat = xdat; v.xdrop = xdrop;
      vecs.push_back(v);
   endtask

   // Runs one round with the beats in q_id/q_dat; expected result from the model unless use_x
   task automatic run_round(input string tag, input logic [7:0] mask, input bit gaps, input bit use_x,
                            input logic [2:0] xid, input logic [31:0] xdat, input logic [7:0] xdrop);
      logic [7:0]  pend;
      logic [2:0]  bid;
      logic [31:0] bdat;
      int          drop, n;
      bit          have;
      pend = mask; drop = 0; n = 0; have = 0; bid = 0; bdat = 0;
      while (pend != 0 && n < q_id.size()) begin
         if (pend[q_id[n]]) begin
            pend[q_id[n]] = 1'b0;
            if (!have || better(q_id[n], q_dat[n], bid, bdat)) begin
               bid = q_id[n];
               bdat = q_dat[n];
            end
            have = 1;
         end else if (drop < 255) drop++;
         n++;
      end
      if (use_x) begin
         bid = xid; bdat = xdat; drop = int'(xdrop);
      end
      bus.round_start = 1'b1; bus.task_mask = mask;
      tick();
      bus.round_start = 1'b0; bus.task_mask = 8'($urandom);
      chk({tag, "_rdy"}, 32'(bus.score_rdy), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            bus.score_vld = 1'b0; bus.round_start = 1'($urandom_range(0, 1));
            tick();
         end
         bus.score_vld = 1'b1; bus.score_id = q_id[i]; bus.score_dat = q_dat[i];
         tick();
      end
      bus.score_vld = 1'b0; bus.round_start = 1'b0;
      chk({tag, "_vld"}, 32'(bus.sel_vld), 32'd1);
      chk({tag, "_id"}, 32'(bus.sel_id), 32'(bid));
      chk({tag, "_score"}, bus.sel_score, bdat);
      chk({tag, "_empty"}, 32'(bus.sel_empty), 32'd0);
      chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'(drop));
`ifdef SCORE_SEL_TIMEOUT_EN
      chk({tag, "_tmo"}, 32'(bus.sel_timeout), 32'd0);
`endif
      repeat ($urandom_range(0, 3)) begin
         tick();
         chk({tag, "_hold_vld"}, 32'(bus.sel_vld), 32'd1);
         chk({tag, "_hold_score"}, bus.sel_score, bdat);
      end
      bus.sel_rdy = 1'b1;
      tick();
      bus.sel_rdy = 1'b0;
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] m;
      int         n;
      specials = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h7FC0_0000,
                   32'hFFC0_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001, 32'h8000_0001};
      bus.round_start = 1'b0; bus.task_mask = '0; bus.score_vld = 1'b0;
      bus.score_id = '0; bus.score_dat = '0; bus.sel_rdy = 1'b0;
      repeat (2) tick();
      chk("rst_vld", 32'(bus.sel_vld), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdy", 32'(bus.score_rdy), 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
      chk("rst_empty", 32'(bus.sel_empty), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      tick();

      add_vec(8'h0F, 4, 0, 32'h4040_0000, 1, 32'h3FC0_0000, 2, 32'hC000_0000, 3, 32'h3F00_0000, 2, 32'hC000_0000, 0);
      add_vec(8'h05, 2, 2, 32'h3F80_0000, 0, 32'h3F80_0000, 0, 0, 0, 0, 0, 32'h3F80_0000, 0);
      add_vec(8'h03, 4, 1, 32'h4080_0000, 1, 32'h3DCC_CCCD, 5, 32'h0, 0, 32'h4100_0000, 1, 32'h4080_0000, 2);
      add_vec(8'h03, 2, 0, 32'h7FC0_0000, 1, 32'hFF80_0000, 0, 0, 0, 0, 1, 32'hFF80_0000, 0);
      add_vec(8'h06, 2, 2, 32'h7FC0_0001, 1, 32'hFFC0_0000, 0, 0, 0, 0, 1, 32'hFFC0_0000, 0);
      add_vec(8'h09, 2, 3, 32'h0, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 32'h8000_0000, 0);
      add_vec(8'h30, 2, 4, 32'hBF80_0000, 5, 32'hC000_0000, 0, 0, 0, 0, 5, 32'hC000_0000, 0);
      add_vec(8'h03, 2, 1, 32'h0, 0, 32'h0000_0001, 0, 0, 0, 0, 1, 32'h0, 0);
      foreach (vecs[k]) begin
         q_id.delete(); q_dat.delete();
         for (int i = 0; i < vecs[k].n; i++) begin
            q_id.push_back(vecs[k].id[i]);
            q_dat.push_back(vecs[k].dat[i]);
         end
         run_round($sformatf("vec%0d", k), vecs[k].mask, 1'b0, 1'b1, vecs[k].xid, vecs[k].xdat, vecs[k].xdrop);
      end

      // Empty round, held result, and a round_start coinciding with the handshake
      bus.round_start = 1'b1; bus.task_mask = 8'h00;
      tick();
      bus.round_start = 1'b0;
      chk("empty_vld", 32'(bus.sel_vld), 32'd1);
      chk("empty_flag", 32'(bus.sel_empty), 32'd1);
      chk("empty_id", 32'(bus.sel_id), 32'd0);
      chk("empty_score", bus.sel_score, 32'd0);
      repeat (5) begin
         tick();
         chk("empty_hold_vld", 32'(bus.sel_vld), 32'd1);
         chk("empty_hold_flag", 32'(bus.sel_empty), 32'd1);
         chk("empty_hold_busy", 32'(bus.busy), 32'd1);
      end
      bus.sel_rdy = 1'b1; bus.round_start = 1'b1; bus.task_mask = 8'hFF;
      tick();
      bus.sel_rdy = 1'b0; bus.round_start = 1'b0;
      chk("hs_busy", 32'(bus.busy), 32'd0);
      chk("hs_vld", 32'(bus.sel_vld), 32'd0);
      tick();
      chk("hs_ignored", 32'(bus.busy), 32'd0);

      // drop_cnt saturation
      q_id.delete(); q_dat.delete();
      repeat (260) begin
         q_id.push_back(3'd7);
         q_dat.push_back(32'h0);
      end
      q_id.push_back(3'd0); q_dat.push_back(32'h3F80_0000);
      run_round("sat", 8'h01, 1'b0, 1'b1, 0, 32'h3F80_0000, 8'd255);

      // Asynchronous reset in the middle of a round
      bus.round_start = 1'b1; bus.task_mask = 8'h07;
      tick();
      bus.round_start = 1'b0;
      bus.score_vld = 1'b1; bus.score_id = 3'd7; bus.score_dat = 32'h3F80_0000;
      tick();
      bus.score_id = 3'd1;
      tick();
      bus.score_vld = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_rdy", 32'(bus.score_rdy), 32'd0);
      chk("arst_drop", 32'(bus.drop_cnt), 32'd0);
      chk("arst_id", 32'(bus.sel_id), 32'd0);
      chk("arst_score", bus.sel_score, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      q_id.delete(); q_dat.delete();
      q_id.push_back(3'd0); q_dat.push_back(32'h0);
      run_round("after_rst", 8'h01, 1'b0, 1'b1, 0, 32'h0, 0);

      // Random rounds against the model
      for (int r = 0; r < 40; r++) begin
         m = 8'($urandom_range(1, 255));
         q_id.delete(); q_dat.delete();
         repeat ($urandom_range(0, 6)) begin
            q_id.push_back(3'($urandom));
            q_dat.push_back(rnd_dat());
         end
         n = $urandom_range(0, 7);
         for (int i = 0; i < 8; i++)
            if (m[(i + n) % 8]) begin
               q_id.push_back(3'((i + n) % 8));
               q_dat.push_back(rnd_dat());
            end
         run_round($sformatf("rnd%0d", r), m, 1'b1, 1'b0, 0, 0, 0);
      end

`ifdef SCORE_SEL_TIMEOUT_EN
      bus.round_start = 1'b1; bus.task_mask = 8'h07;
      tick();
      bus.round_start = 1'b0;
      bus.score_vld = 1'b1; bus.score_id = 3'd1; bus.score_dat = 32'h4000_0000;
      tick();
      bus.score_vld = 1'b0;
      n = 1;
      while (!bus.sel_vld && n < 100) begin
         tick();
         n++;
      end
      chk("tmo_latency", 32'(n), 32'd16);
      chk("tmo_flag", 32'(bus.sel_timeout), 32'd1);
      chk("tmo_id", 32'(bus.sel_id), 32'd1);
      chk("tmo_score", bus.sel_score, 32'h4000_0000);
      chk("tmo_empty", 32'(bus.sel_empty), 32'd0);
      bus.sel_rdy = 1'b1;
      tick();
      bus.sel_rdy = 1'b0;
      bus.round_start = 1'b1; bus.task_mask = 8'h01;
      tick();
      bus.round_start = 1'b0;
      n = 0;
      while (!bus.sel_vld && n < 100) begin
         tick();
         n++;
      end
      chk("tmo0_latency", 32'(n), 32'd16);
      chk("tmo0_empty", 32'(bus.sel_empty), 32'd1);
      chk("tmo0_id", 32'(bus.sel_id), 32'd0);
      chk("tmo0_score", bus.sel_score, 32'd0);
      chk("tmo0_flag", 32'(bus.sel_timeout), 32'd1);
      bus.sel_rdy = 1'b1;
      tick();
      bus.sel_rdy = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
